logic_unit_i8_scheduler: RTL

//   Shares one pipelined bitwise logic unit (NOT/AND/OR/XOR, WIDTH bits) among NUM_REQ requesters.

---
 rtl/logic_unit_i8_scheduler.sv | 70 +++++++
 1 files changed

// File: rtl/logic_unit_i8_scheduler.sv
// logic_unit_i8_scheduler: round-robin sequencer sharing one pipelined bitwise logic unit among requesters
module logic_unit_i8_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_y,
    output logic                     busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] ptr, grant, gnt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] pipe [LATENCY];
    logic [1:0] op;
    logic [WIDTH-1:0] a, b, res;
    logic acc;
    always_comb begin
        gnt = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid[PW'((int'(ptr) + k) % NUM_REQ)]) gnt = PW'((int'(ptr) + k) % NUM_REQ);
    end
    assign acc = (state == IDLE) && (|req_valid);
    assign op  = req_op[2*gnt +: 2];
    assign a   = req_a[WIDTH*gnt +: WIDTH];
    assign b   = req_b[WIDTH*gnt +: WIDTH];
    assign res = op == 2'd0 ? ~a : op == 2'd1 ? a & b : op == 2'd2 ? a | b : a ^ b;
    always_comb begin
        state_nxt  = state;
        req_ready  = acc ? NUM_REQ'(1) << gnt : '0;
        resp_valid = state == RESP ? NUM_REQ'(1) << grant : '0;
        busy       = state != IDLE;
        if (acc) state_nxt = EXEC;
        if (state == EXEC && cnt == CW'(1)) state_nxt = RESP;
        if (state == RESP && resp_ready[grant]) state_nxt = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= PW'(NUM_REQ - 1);
            grant  <= '0;
            cnt    <= '0;
            resp_y <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                grant   <= gnt;
                cnt     <= CW'(LATENCY);
                pipe[0] <= res;
            end
            if (state == EXEC) begin
                for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) resp_y <= pipe[LATENCY-1];
            end
            if (state == RESP && resp_ready[grant]) ptr <= grant;
        end
    end
endmodule
